exec_unit_md: RTL and testbench

- Parametrised successor of the single-cycle integer ALU: one reservation-station-fed execution unit.
- Executes base RV integer ops plus M-extension multiply/divide under a valid/ready handshake.
- Carries the issuing tag through to the common data bus (CDB) stage.
- ALU ops are registered with 1-cycle latency; M ops run iteratively (radix-2) with fixed latency.

---
 rtl/exec_unit_md.sv | 216 +++++++++++++++++++++
 tb/tb_exec_unit_md.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_md.sv
// exec_unit_md: reservation-station-fed integer execution unit.
// One-cycle ALU ops plus radix-2 iterative multiply/divide; tag travels with the result.
module exec_unit_md #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_op,
  input  logic [XLEN-1:0]  in_vj,
  input  logic [XLEN-1:0]  in_vk,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        w_f3;
  logic              w_m;
  logic              w_f7;
  logic              w_accept;
  logic              w_go_m;
  logic              w_last;
  logic [SW-1:0]     w_sh;
  logic [XLEN-1:0]   w_alu;
  logic signed [XLEN-1:0] w_sra;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_aabs;
  logic [XLEN-1:0]   w_babs;

  logic [2*XLEN-1:0] r_p;
  logic [XLEN-1:0]   r_b;
  logic [SW-1:0]     r_cnt;
  logic              r_isdiv;
  logic              r_hi;
  logic              r_rem;
  logic              r_neg;
  logic              r_rneg;
  logic [XLEN-1:0]   r_result;
  logic [TAG_W-1:0]  r_tag;

  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_dsh;
  logic [XLEN:0]     w_sub;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mstep;
  logic [2*XLEN-1:0] w_dstep;
  logic [2*XLEN-1:0] w_pn;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_mres;
  logic              w_unused;

  assign w_f3     = in_op[9:7];
  assign w_m      = in_op[6];
  assign w_f7     = in_op[5];
  assign w_sh     = in_vk[SW-1:0];
  assign w_accept = in_valid & in_ready;
  assign w_go_m   = w_accept & w_m & ENABLE_M;
  assign w_last   = (r_cnt == SW'(XLEN - 1));
  assign w_unused = ^{in_op[4:0], w_sub[XLEN]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_next = w_go_m ? S_BUSY : S_DONE;
        end
        S_BUSY: begin
          if (w_last) w_next = S_DONE;
        end
        S_DONE: begin
          if (w_accept)       w_next = w_go_m ? S_BUSY : S_DONE;
          else if (out_ready) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_BUSY);
    in_ready  = ~flush &
                ((r_state == S_IDLE) |
                 ((r_state == S_DONE) & out_ready));
  end

  assign out_result = r_result;
  assign out_tag    = r_tag;

  assign w_sra = $signed(in_vj) >>> w_sh;

  always_comb begin
    w_alu = '0;
    unique case (w_f3)
      3'b000: w_alu = w_f7 ? (in_vj - in_vk) : (in_vj + in_vk);
      3'b001: w_alu = in_vj << w_sh;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, $signed(in_vj) < $signed(in_vk)};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, in_vj < in_vk};
      3'b100: w_alu = in_vj ^ in_vk;
      3'b101: w_alu = w_f7 ? w_sra : (in_vj >> w_sh);
      3'b110: w_alu = in_vj | in_vk;
      3'b111: w_alu = in_vj & in_vk;
      default: w_alu = '0;
    endcase
    if (w_m) w_alu = '0;
  end

  // Operand signedness: MULH/MULHSU/DIV/REM treat vj signed; MULH/DIV/REM treat vk signed
  assign w_sa = in_vj[XLEN-1] &
                ((w_f3 == 3'b001) | (w_f3 == 3'b010) |
                 (w_f3 == 3'b100) | (w_f3 == 3'b110));
  assign w_sb = in_vk[XLEN-1] &
                ((w_f3 == 3'b001) | (w_f3 == 3'b100) |
                 (w_f3 == 3'b110));
  assign w_aabs = w_sa ? -in_vj : in_vj;
  assign w_babs = w_sb ? -in_vk : in_vk;

  assign w_hi = r_p[2*XLEN-1:XLEN];
  assign w_lo = r_p[XLEN-1:0];

  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
  assign w_mstep = {w_sum, w_lo[XLEN-1:1]};

  assign w_dsh   = {w_hi, w_lo[XLEN-1]};
  assign w_ge    = (w_dsh >= {1'b0, r_b});
  assign w_sub   = w_dsh - {1'b0, r_b};
  assign w_dstep = w_ge ? {w_sub[XLEN-1:0], w_lo[XLEN-2:0], 1'b1}
                        : {w_dsh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};

  assign w_pn   = r_isdiv ? w_dstep : w_mstep;
  assign w_prod = r_neg ? -w_pn : w_pn;
  assign w_q    = w_pn[XLEN-1:0];
  assign w_r    = w_pn[2*XLEN-1:XLEN];

  always_comb begin
    if (!r_isdiv)   w_mres = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    else if (r_rem) w_mres = r_rneg ? -w_r : w_r;
    else            w_mres = r_neg ? -w_q : w_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_isdiv  <= 1'b0;
      r_hi     <= 1'b0;
      r_rem    <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_tag <= in_tag;
      if (w_go_m) begin
        r_isdiv <= w_f3[2];
        r_hi    <= (w_f3[1:0] != 2'b00);
        r_rem   <= w_f3[1];
        r_rneg  <= w_sa;
        r_cnt   <= '0;
        if (w_f3[2]) begin
          // Divide by zero keeps quotient all ones: no sign fixup
          r_neg <= (w_sa ^ w_sb) & (in_vk != '0);
          r_p   <= {{XLEN{1'b0}}, w_aabs};
          r_b   <= w_babs;
        end else begin
          r_neg <= w_sa ^ w_sb;
          r_p   <= {{XLEN{1'b0}}, w_babs};
          r_b   <= w_aabs;
        end
      end else begin
        r_result <= w_alu;
      end
    end else if (r_state == S_BUSY) begin
      r_p   <= w_pn;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_mres;
    end
  end

endmodule

// File: tb/tb_exec_unit_md.sv
// tb_exec_unit_md: randomized self-checking bench for exec_unit_md.
// Reference model uses plain 64-bit arithmetic on RISC-V op semantics.
module tb_exec_unit_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_op = '0;
  logic [31:0] in_vj = '0;
  logic [31:0] in_vk = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        busy;

  int errors = 0;
  int checks = 0;

  exec_unit_md #(.XLEN(32), .TAG_W(4), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vj(in_vj), .in_vk(in_vk), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic [2:0] f3, input logic m,
                                    input logic f7);
    logic [4:0] junk;
    junk = 5'($urandom);
    return {f3, m, f7, junk};
  endfunction

  function automatic logic [31:0] ref_model(input logic [9:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs, ps;
    logic [63:0] ua, ub, r;
    logic [4:0]  sh;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ubs = ub;
    sh  = b[4:0];
    r   = '0;
    if (!op[6]) begin
      case (op[9:7])
        3'd0: r = op[5] ? ua - ub : ua + ub;
        3'd1: r = ua << sh;
        3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
        3'd3: r = (a < b) ? 64'd1 : 64'd0;
        3'd4: r = ua ^ ub;
        3'd5: begin
          if (op[5]) begin ps = sa >>> sh; r = ps; end
          else r = ua >> sh;
        end
        3'd6: r = ua | ub;
        default: r = ua & ub;
      endcase
    end else begin
      case (op[9:7])
        3'd0: begin ps = sa * sb; r = ps; end
        3'd1: begin ps = sa * sb; r = ps; r = r >> 32; end
        3'd2: begin ps = sa * ubs; r = ps; r = r >> 32; end
        3'd3: begin r = ua * ub; r = r >> 32; end
        3'd4: begin
          if (b == 0) r = '1;
          else begin ps = sa / sb; r = ps; end
        end
        3'd5: begin
          if (b == 0) r = '1;
          else r = ua / ub;
        end
        3'd6: begin
          if (b == 0) r = ua;
          else begin ps = sa % sb; r = ps; end
        end
        default: begin
          if (b == 0) r = ua;
          else r = ua % ub;
        end
      endcase
    end
    return r[31:0];
  endfunction

  task automatic run_op(input logic [9:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        output logic [31:0] res, output logic [3:0] t,
                        output int lat, output int bcnt);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op;
    in_vj = a;
    in_vk = b;
    in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    bcnt = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = out_result;
    t = out_tag;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
    checks++;
    if (out_result !== 32'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h tag=%h required 0 0", out_result, out_tag);
    end
  endtask

  task automatic test_alu();
    logic [9:0]  ops[4];
    logic [31:0] va[4], vb[4], ex[4];
    logic [31:0] res, a, b, e;
    logic [9:0]  op;
    logic [3:0]  t;
    int lat, bc;
    ops[0] = mk(3'd0, 1'b0, 1'b0); va[0] = 32'd7;        vb[0] = 32'hFFFF_FFFD; ex[0] = 32'd4;
    ops[1] = mk(3'd0, 1'b0, 1'b1); va[1] = 32'd5;        vb[1] = 32'd7;         ex[1] = 32'hFFFF_FFFE;
    ops[2] = mk(3'd5, 1'b0, 1'b1); va[2] = 32'h8000_0000; vb[2] = 32'd4;        ex[2] = 32'hF800_0000;
    ops[3] = mk(3'd3, 1'b0, 1'b0); va[3] = 32'd1;        vb[3] = 32'hFFFF_FFFF; ex[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], 4'h5, res, t, lat, bc);
      checks++;
      if (res !== ex[i] || t !== 4'h5 || lat != 1) begin
        errors++;
        $display("FAIL alu_dir%0d: result=%h tag=%h lat=%0d required %h 5 1",
                 i, res, t, lat, ex[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      op = mk(3'($urandom), 1'b0, 1'($urandom));
      a = $urandom;
      b = $urandom;
      e = ref_model(op, a, b);
      run_op(op, a, b, 4'(i), res, t, lat, bc);
      checks++;
      if (res !== e || t !== 4'(i) || lat != 1) begin
        errors++;
        $display("FAIL alu_rnd op=%h a=%h b=%h: result=%h tag=%h lat=%0d required %h %h 1",
                 op, a, b, res, t, lat, e, 4'(i));
      end
    end
  endtask

  task automatic test_mul();
    logic [9:0]  ops[3];
    logic [31:0] va[3], vb[3], ex[3];
    logic [31:0] res, a, b, e;
    logic [9:0]  op;
    logic [3:0]  t;
    int lat, bc;
    ops[0] = mk(3'd1, 1'b1, 1'b0); va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; ex[0] = 32'h4000_0000;
    ops[1] = mk(3'd2, 1'b1, 1'b0); va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; ex[1] = 32'hFFFF_FFFF;
    ops[2] = mk(3'd0, 1'b1, 1'b0); va[2] = 32'd6;         vb[2] = 32'd7;         ex[2] = 32'd42;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], va[i], vb[i], 4'hC, res, t, lat, bc);
      checks++;
      if (res !== ex[i] || t !== 4'hC) begin
        errors++;
        $display("FAIL mul_dir%0d: result=%h tag=%h required %h c", i, res, t, ex[i]);
      end
      checks++;
      if (lat != 33 || bc != 32) begin
        errors++;
        $display("FAIL mul_lat%0d: lat=%0d busy=%0d required 33 32", i, lat, bc);
      end
    end
    for (int i = 0; i < 6; i++) begin
      op = mk(3'($urandom_range(0, 3)), 1'b1, 1'($urandom));
      a = $urandom;
      b = $urandom;
      e = ref_model(op, a, b);
      run_op(op, a, b, 4'(i), res, t, lat, bc);
      checks++;
      if (res !== e || lat != 33) begin
        errors++;
        $display("FAIL mul_rnd op=%h a=%h b=%h: result=%h lat=%0d required %h 33",
                 op, a, b, res, lat, e);
      end
    end
  endtask

  task automatic test_div();
    logic [9:0]  ops[6];
    logic [31:0] va[6], vb[6], ex[6];
    logic [31:0] res, a, b, e;
    logic [9:0]  op;
    logic [3:0]  t;
    int lat, bc;
    ops[0] = mk(3'd4, 1'b1, 1'b0); va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2; ex[0] = 32'hFFFF_FFFD;
    ops[1] = mk(3'd6, 1'b1, 1'b0); va[1] = 32'hFFFF_FFF9; vb[1] = 32'd2; ex[1] = 32'hFFFF_FFFF;
    ops[2] = mk(3'd5, 1'b1, 1'b0); va[2] = 32'd10;        vb[2] = 32'd0; ex[2] = 32'hFFFF_FFFF;
    ops[3] = mk(3'd7, 1'b1, 1'b0); va[3] = 32'd10;        vb[3] = 32'd0; ex[3] = 32'd10;
    ops[4] = mk(3'd4, 1'b1, 1'b0); va[4] = 32'h8000_0000; vb[4] = 32'hFFFF_FFFF; ex[4] = 32'h8000_0000;
    ops[5] = mk(3'd6, 1'b1, 1'b0); va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_FFFF; ex[5] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], 4'h3, res, t, lat, bc);
      checks++;
      if (res !== ex[i] || t !== 4'h3 || lat != 33) begin
        errors++;
        $display("FAIL div_dir%0d: result=%h tag=%h lat=%0d required %h 3 33",
                 i, res, t, lat, ex[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      op = mk(3'($urandom_range(4, 7)), 1'b1, 1'($urandom));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      e = ref_model(op, a, b);
      run_op(op, a, b, 4'(i), res, t, lat, bc);
      checks++;
      if (res !== e || lat != 33) begin
        errors++;
        $display("FAIL div_rnd op=%h a=%h b=%h: result=%h lat=%0d required %h 33",
                 op, a, b, res, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, ex1, ex2;
    logic [9:0]  op2;
    a = $urandom;
    b = $urandom;
    ex1 = a + b;
    ex2 = a ^ b;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = mk(3'd0, 1'b0, 1'b0);
    in_vj = a;
    in_vk = b;
    in_tag = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== ex1) begin
      errors++;
      $display("FAIL bp_first: valid=%b result=%h required 1 %h", out_valid, out_result, ex1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== ex1 || out_tag !== 4'h6 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b result=%h tag=%h ready=%b required 1 %h 6 0",
                 i, out_valid, out_result, out_tag, in_ready, ex1);
      end
    end
    op2 = mk(3'd4, 1'b0, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = op2;
    in_tag = 4'h9;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== ex2 || out_tag !== 4'h9) begin
      errors++;
      $display("FAIL bp_next: valid=%b result=%h tag=%h required 1 %h 9",
               out_valid, out_result, out_tag, ex2);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [3:0]  t;
    int lat, bc;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_op = mk(3'd4, 1'b1, 1'b0);
    in_vj = 32'd1000;
    in_vk = 32'd7;
    in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: busy=%b required 1", busy);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = mk(3'd0, 1'b0, 1'b0);
    in_tag = 4'h7;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b valid=%b required 0 0", busy, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_quiet: activity=1 required 0");
    end
    run_op(mk(3'd0, 1'b0, 1'b0), 32'd100, 32'd23, 4'hA, res, t, lat, bc);
    checks++;
    if (res !== 32'd123 || t !== 4'hA || lat != 1) begin
      errors++;
      $display("FAIL flush_after: result=%h tag=%h lat=%0d required 7b a 1", res, t, lat);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_op = mk(3'd0, 1'b1, 1'b0);
    in_vj = 32'd6;
    in_vk = 32'd7;
    in_tag = 4'h4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop: busy=%b valid=%b required 0 0", busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_result !== 32'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL arst_release: ready=%b result=%h tag=%h required 1 0 0",
               in_ready, out_result, out_tag);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL arst_quiet: out_valid seen=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
